// File: rtl/decoder_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_sched_pkg
//  Purpose  : Shared types and round-robin helper for the decoder frame
//             scheduler and its arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package decoder_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FWD_IN   = 2'd1,
        WAIT_OUT = 2'd2
    } sched_state_t;

    localparam int STAT_W = 16;
    localparam int RR_MAX = 32;

    // First set bit of req scanning last+1 upward with wrap at n; returns last if req is empty.
    function automatic logic [4:0] rr_pick(input logic [RR_MAX-1:0] req,
                                           input logic [4:0]        last,
                                           input int                n);
        logic [5:0] idx;
        logic [4:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= RR_MAX; i++) begin
            idx = {1'b0, last} + 6'(i);
            if (idx >= 6'(n)) begin
                idx = idx - 6'(n);
            end
            if (!found && (i <= n) && req[idx[4:0]]) begin
                pick  = idx[4:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational N_REQ-way round-robin pick (N_REQ <= 32) plus an
//             any-request flag.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import decoder_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [ID_W-1:0]  pick,
    output logic             any_req
);

    logic [RR_MAX-1:0] req_ext;

    assign req_ext = RR_MAX'(req);
    assign pick    = ID_W'(rr_pick(req_ext, 5'(last), N_REQ));
    assign any_req = |req;

endmodule
`default_nettype wire

// File: rtl/decoder_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_frame_sched
//  Purpose  : Round-robin frame scheduler sharing one decoder between N_REQ
//             requesters; grant is held from first LLR beat to codeword tlast.
//             Define DECODER_SCHED_STATS_EN for per-requester frame counters.
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_frame_sched
    import decoder_sched_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int IN_W     = 32,
    parameter  int OUT_W    = 32,
    parameter  int IN_BEATS = 8,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ*IN_W-1:0]   req_tdata,
    input  logic [N_REQ-1:0]        req_tvalid,
    output logic [N_REQ-1:0]        req_tready,
    output logic [IN_W-1:0]         dec_in_tdata,
    output logic                    dec_in_tvalid,
    output logic                    dec_in_tlast,
    input  logic                    dec_in_tready,
    input  logic [OUT_W-1:0]        dec_out_tdata,
    input  logic                    dec_out_tvalid,
    input  logic                    dec_out_tlast,
    output logic                    dec_out_tready,
    output logic [N_REQ*OUT_W-1:0]  rsp_tdata,
    output logic [N_REQ-1:0]        rsp_tvalid,
    output logic [N_REQ-1:0]        rsp_tlast,
    input  logic [N_REQ-1:0]        rsp_tready,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic [N_REQ*STAT_W-1:0] stat_frames
);

    localparam int              CNT_W     = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_BEATS - 1);

    sched_state_t     state_q,      state_d;
    logic [ID_W-1:0]  grant_id_q,   grant_id_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [CNT_W-1:0] beat_cnt_q,   beat_cnt_d;
    logic             busy_q,       busy_d;

    logic [ID_W-1:0]  arb_pick;
    logic             arb_any;
    logic             in_fwd;
    logic             out_fwd;
    logic             in_hs;
    logic             out_hs;
    logic             last_beat;

    rr_arbiter #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req     (req_tvalid),
        .last    (last_grant_q),
        .pick    (arb_pick),
        .any_req (arb_any)
    );

    assign in_fwd    = (state_q == FWD_IN);
    assign out_fwd   = (state_q == WAIT_OUT);
    assign in_hs     = dec_in_tvalid && dec_in_tready;
    assign out_hs    = dec_out_tvalid && dec_out_tready;
    assign last_beat = (beat_cnt_q == LAST_BEAT);
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;

    // Stream muxing is purely combinational so a granted frame sees no extra latency.
    always_comb begin
        req_tready     = '0;
        dec_in_tdata   = '0;
        dec_in_tvalid  = 1'b0;
        dec_in_tlast   = 1'b0;
        rsp_tdata      = '0;
        rsp_tvalid     = '0;
        rsp_tlast      = '0;
        dec_out_tready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                if (in_fwd) begin
                    dec_in_tdata  = req_tdata[i*IN_W +: IN_W];
                    dec_in_tvalid = req_tvalid[i];
                    dec_in_tlast  = last_beat;
                    req_tready[i] = dec_in_tready;
                end
                if (out_fwd) begin
                    rsp_tdata[i*OUT_W +: OUT_W] = dec_out_tdata;
                    rsp_tvalid[i]               = dec_out_tvalid;
                    rsp_tlast[i]                = dec_out_tlast;
                    dec_out_tready              = rsp_tready[i];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_id_d = arb_pick;
                    state_d    = FWD_IN;
                end
            end
            FWD_IN: begin
                if (in_hs) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = WAIT_OUT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            WAIT_OUT: begin
                if (out_hs && dec_out_tlast) begin
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Reset value of last_grant makes requester 0 the first in line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            beat_cnt_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            busy_q       <= busy_d;
        end
    end

`ifdef DECODER_SCHED_STATS_EN
    logic              done_hs;
    logic [STAT_W-1:0] stat_q [N_REQ];
    logic [STAT_W-1:0] stat_d [N_REQ];

    assign done_hs = out_fwd && out_hs && dec_out_tlast;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            stat_d[i] = stat_q[i];
            if (done_hs && (grant_id_q == ID_W'(i)) && (stat_q[i] != '1)) begin
                stat_d[i] = stat_q[i] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat_out
        assign stat_frames[gi*STAT_W +: STAT_W] = stat_q[gi];
    end
`else
    assign stat_frames = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_frame_sched
//  Purpose  : Scoreboard bench for decoder_frame_sched with requester sources
//             and a two-beat decoder model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_frame_sched;
    import decoder_sched_pkg::STAT_W;

    localparam int N_REQ    = 4;
    localparam int IN_W     = 32;
    localparam int OUT_W    = 32;
    localparam int IN_BEATS = 8;
    localparam int ID_W     = 2;
    localparam int CW_BEATS = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        logic            last;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ*IN_W-1:0]   req_tdata;
    logic [N_REQ-1:0]        req_tvalid;
    logic [N_REQ-1:0]        req_tready;
    logic [IN_W-1:0]         dec_in_tdata;
    logic                    dec_in_tvalid;
    logic                    dec_in_tlast;
    logic                    dec_in_tready;
    logic [OUT_W-1:0]        dec_out_tdata;
    logic                    dec_out_tvalid;
    logic                    dec_out_tlast;
    logic                    dec_out_tready;
    logic [N_REQ*OUT_W-1:0]  rsp_tdata;
    logic [N_REQ-1:0]        rsp_tvalid;
    logic [N_REQ-1:0]        rsp_tlast;
    logic [N_REQ-1:0]        rsp_tready;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;
    logic [N_REQ*STAT_W-1:0] stat_frames;

    decoder_frame_sched #(
        .N_REQ          (N_REQ),
        .IN_W           (IN_W),
        .OUT_W          (OUT_W),
        .IN_BEATS       (IN_BEATS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_tdata      (req_tdata),
        .req_tvalid     (req_tvalid),
        .req_tready     (req_tready),
        .dec_in_tdata   (dec_in_tdata),
        .dec_in_tvalid  (dec_in_tvalid),
        .dec_in_tlast   (dec_in_tlast),
        .dec_in_tready  (dec_in_tready),
        .dec_out_tdata  (dec_out_tdata),
        .dec_out_tvalid (dec_out_tvalid),
        .dec_out_tlast  (dec_out_tlast),
        .dec_out_tready (dec_out_tready),
        .rsp_tdata      (rsp_tdata),
        .rsp_tvalid     (rsp_tvalid),
        .rsp_tlast      (rsp_tlast),
        .rsp_tready     (rsp_tready),
        .grant_id       (grant_id),
        .busy           (busy),
        .stat_frames    (stat_frames)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] src_word(input int id, input int frm, input int b);
        return {8'hA0 + 8'(id), 8'(frm), 8'h5A, 8'(b)};
    endfunction

    // Requester sources, decoder model and scoreboard queues
    int             src_left [N_REQ];
    int             src_beat [N_REQ];
    int             src_frm  [N_REQ];
    logic           src_toggle [N_REQ];
    logic           src_phase;
    logic [N_REQ-1:0] rsp_rdy;
    int             dm_left;
    int             dm_k;
    int             dm_in_cnt;
    logic [31:0]    dm_base;
    int             nf [N_REQ];
    beat_t          exp_in_q[$];
    beat_t          exp_out_q[$];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_tvalid[i]             = (src_left[i] != 0) && (!src_toggle[i] || src_phase);
            req_tdata[i*IN_W +: IN_W] = src_word(i, src_frm[i], src_beat[i]);
        end
    end

    assign rsp_tready     = rsp_rdy;
    assign dec_out_tvalid = (dm_left != 0);
    assign dec_out_tdata  = dm_base + 32'(dm_k);
    assign dec_out_tlast  = (dm_left == 1);

    initial begin : bus_proc
        logic             in_hs;
        logic             out_hs;
        logic             in_last;
        logic [31:0]      in_data;
        logic [N_REQ-1:0] src_hs;
        logic [N_REQ*OUT_W-1:0] slice_m;
        beat_t            e;
        for (int i = 0; i < N_REQ; i++) begin
            src_left[i] = 0; src_beat[i] = 0; src_frm[i] = 0; src_toggle[i] = 1'b0;
        end
        src_phase = 1'b0; dm_left = 0; dm_k = 0; dm_in_cnt = 0; dm_base = '0;
        forever begin
            @(negedge clk);
            in_hs   = dec_in_tvalid && dec_in_tready;
            out_hs  = dec_out_tvalid && dec_out_tready;
            in_data = dec_in_tdata;
            in_last = dec_in_tlast;
            src_hs  = req_tvalid & req_tready;
            if (in_hs) begin
                check_val("in_expected", exp_in_q.size() != 0, 1);
                if (exp_in_q.size() != 0) begin
                    e = exp_in_q.pop_front();
                    check_val("in_data", dec_in_tdata, e.data);
                    check_val("in_last", dec_in_tlast, e.last);
                    check_val("in_ready_route", req_tready, N_REQ'(1) << e.id);
                    check_val("grant_id", grant_id, e.id);
                    check_val("busy_fwd", busy, 1);
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (rsp_tvalid[i] && rsp_tready[i]) begin
                    check_val("rsp_expected", exp_out_q.size() != 0, 1);
                    if (exp_out_q.size() != 0) begin
                        e = exp_out_q.pop_front();
                        slice_m = {{(N_REQ-1)*OUT_W{1'b0}}, {OUT_W{1'b1}}} << (i*OUT_W);
                        check_val("rsp_route", rsp_tvalid, N_REQ'(1) << e.id);
                        check_val("rsp_data", rsp_tdata[i*OUT_W +: OUT_W], e.data);
                        check_val("rsp_last", rsp_tlast[i], e.last);
                        check_val("rsp_other_zero", |(rsp_tdata & ~slice_m), 0);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int i = 0; i < N_REQ; i++) begin
                    src_left[i] = 0; src_beat[i] = 0;
                end
                dm_left = 0; dm_k = 0; dm_in_cnt = 0;
            end else begin
                src_phase = ~src_phase;
                for (int i = 0; i < N_REQ; i++) begin
                    if (src_hs[i]) begin
                        if (src_beat[i] == IN_BEATS - 1) begin
                            src_beat[i] = 0;
                            src_frm[i]  = src_frm[i] + 1;
                            src_left[i] = src_left[i] - 1;
                        end else begin
                            src_beat[i] = src_beat[i] + 1;
                        end
                    end
                end
                if (out_hs) begin
                    dm_k    = dm_k + 1;
                    dm_left = dm_left - 1;
                end
                if (in_hs) begin
                    if (dm_in_cnt == 0) dm_base = in_data;
                    dm_in_cnt = dm_in_cnt + 1;
                    if (in_last) begin
                        dm_in_cnt = 0;
                        dm_left   = CW_BEATS;
                        dm_k      = 0;
                    end
                end
            end
        end
    end

    task automatic push_frame(input int id);
        beat_t e;
        for (int b = 0; b < IN_BEATS; b++) begin
            e.id = ID_W'(id); e.data = src_word(id, nf[id], b); e.last = (b == IN_BEATS - 1);
            exp_in_q.push_back(e);
        end
        for (int k = 0; k < CW_BEATS; k++) begin
            e.id = ID_W'(id); e.data = src_word(id, nf[id], 0) + 32'(k); e.last = (k == CW_BEATS - 1);
            exp_out_q.push_back(e);
        end
        nf[id] = nf[id] + 1;
    endtask

    task automatic send(input int id, input int n);
        for (int f = 0; f < n; f++) push_frame(id);
        src_left[id] = src_left[id] + n;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk); #3;
            cyc++;
        end while ((exp_in_q.size() != 0 || exp_out_q.size() != 0 || busy) && cyc < 2000);
        check_val({tag, "_in_drained"}, exp_in_q.size(), 0);
        check_val({tag, "_out_drained"}, exp_out_q.size(), 0);
        check_val({tag, "_idle"}, busy, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_req_tready"}, req_tready, 0);
        check_val({tag, "_dec_in"}, {dec_in_tvalid, dec_in_tlast, |dec_in_tdata}, 0);
        check_val({tag, "_dec_out_tready"}, dec_out_tready, 0);
        check_val({tag, "_rsp"}, {rsp_tvalid, rsp_tlast, |rsp_tdata}, 0);
        check_val({tag, "_busy_grant"}, {busy, grant_id}, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0]       held;
        logic [63:0]       exp_stat;
        int                cyc;
        for (int i = 0; i < N_REQ; i++) nf[i] = 0;
        rst           = 1'b0;
        rsp_rdy       = '1;
        dec_in_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check_val("reset_stat", stat_frames, 0);
        @(posedge clk); #3;
        rst = 1'b1;

        // 1: single frame from requester 0
        @(posedge clk); #3;
        send(0, 1);
        wait_done("t1");
        check_val("t1_grant_id", grant_id, 0);

        // 2: all requesters busy for 8 frames, expected order 0,1,2,3,0,1,2,3
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N_REQ; i++) push_frame(i);
        for (int i = 0; i < N_REQ; i++) src_left[i] = src_left[i] + 2;
        wait_done("t2");

        // 3: requester 2 valid toggles every cycle
        src_toggle[2] = 1'b1;
        send(2, 1);
        wait_done("t3");
        src_toggle[2] = 1'b0;

        // 4: requester 3 stalls the second codeword beat for 5 cycles
        held = src_word(3, nf[3], 0) + 32'd1;
        send(3, 1);
        cyc = 0;
        do begin
            @(posedge clk); #3;
            cyc++;
        end while (dm_left != 1 && cyc < 200);
        check_val("t4_reach_beat2", dm_left, 1);
        rsp_rdy[3] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_val("t4_stall_ready", dec_out_tready, 0);
            check_val("t4_stall_valid", rsp_tvalid, 4'b1000);
            check_val("t4_stall_data", rsp_tdata[3*OUT_W +: OUT_W], held);
        end
        @(posedge clk); #3;
        rsp_rdy[3] = 1'b1;
        wait_done("t4");

        // 5: reset while requester 2 waits for its codeword; requester 0 must win next
        send(0, 1);
        wait_done("t5a");
        rsp_rdy[2] = 1'b0;
        send(2, 1);
        cyc = 0;
        do begin
            @(posedge clk); #3;
            cyc++;
        end while ((exp_in_q.size() != 0 || dm_left == 0) && cyc < 200);
        check_val("t5_wait_out", dm_left, CW_BEATS);
        rst = 1'b0;
        exp_in_q.delete();
        exp_out_q.delete();
        @(negedge clk);
        check_quiet("t5_reset");
        @(posedge clk); #3;
        rst        = 1'b1;
        rsp_rdy    = '1;
        nf[2]      = src_frm[2];
        push_frame(0);
        push_frame(1);
        src_left[0] = 1;
        src_left[1] = 1;
        wait_done("t5b");

        // 6: frame counters
        do_reset();
        @(negedge clk);
        check_val("t6_stat_reset", stat_frames, 0);
        @(posedge clk); #3;
        send(1, 3);
        wait_done("t6");
`ifdef DECODER_SCHED_STATS_EN
        exp_stat = {16'd0, 16'd0, 16'd3, 16'd0};
`else
        exp_stat = '0;
`endif
        check_val("t6_stat_frames", stat_frames, exp_stat);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
